// File: rtl/apb_mc_pkg.sv
// Shared state type, default parameters and sizing helper for the
// multi-channel APB completer.
package apb_mc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 10;
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_CH_ADDR_BITS = 8;
  localparam int DEF_TIMEOUT      = 16;

  // Channel index width; a single channel still uses one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Per-access cycle counter; expired is high on the last allowed ACCESS cycle.
module apb_timeout_counter
  import apb_mc_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count_r;

  // Count enabled cycles, saturating at the expiry value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !expired) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_multi_completer.sv
// APB completer that forwards each transfer to one of NUM_CH back-end
// channels selected by address, with a per-access timeout.
module apb_multi_completer
  import apb_mc_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CH_ADDR_BITS = DEF_CH_ADDR_BITS,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic [ADDR_WIDTH-1:0]        paddr,
  input  logic [2:0]                   pprot,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [DATA_WIDTH-1:0]        pwdata,
  input  logic [DATA_WIDTH/8-1:0]      pstrb,
  output logic                         pready,
  output logic [DATA_WIDTH-1:0]        prdata,
  output logic                         pslverr,
  output logic [NUM_CH-1:0]            ch_req,
  output logic [CH_ADDR_BITS-1:0]      ch_addr,
  output logic [2:0]                   ch_prot,
  output logic                         ch_write,
  output logic [DATA_WIDTH-1:0]        ch_wdata,
  output logic [DATA_WIDTH/8-1:0]      ch_strb,
  input  logic [NUM_CH-1:0]            ch_ack,
  input  logic [NUM_CH-1:0]            ch_err,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata
);

  localparam int IDXW = idx_width(NUM_CH);

  state_t                state_r;
  logic [NUM_CH-1:0]     req_r;
  logic [IDXW-1:0]       idx_s;
  logic                  idx_ok_s;
  logic [NUM_CH-1:0]     onehot_s;
  logic                  setup_s;
  logic                  ack_s;
  logic                  err_s;
  logic                  expired_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign setup_s  = psel && !penable;
  assign idx_s    = paddr[CH_ADDR_BITS +: IDXW];
  assign idx_ok_s = (32'(idx_s) < 32'(NUM_CH));

  // Decode the addressed channel into a one-hot request pattern.
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      onehot_s[i] = (idx_s == IDXW'(i));
    end
  end

  // req_r is one-hot during ACCESS, so masking selects only the active channel.
  always_comb begin
    rdata_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rdata_s = rdata_s | (ch_rdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{req_r[i]}});
    end
  end

  assign ack_s = |(ch_ack & req_r);
  assign err_s = |(ch_err & req_r);

  // Dropping psel mid-access withdraws the request in the same cycle.
  assign ch_req = req_r & {NUM_CH{psel}};

  apb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (pclk),
    .rst     (preset),
    .clear   (state_r != ACCESS),
    .enable  (state_r == ACCESS),
    .expired (expired_s)
  );

  // Transfer sequencing, channel request and registered APB response.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_r  <= IDLE;
      req_r    <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      ch_addr  <= '0;
      ch_prot  <= 3'b000;
      ch_write <= 1'b0;
      ch_wdata <= '0;
      ch_strb  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            ch_addr  <= paddr[CH_ADDR_BITS-1:0];
            ch_prot  <= pprot;
            ch_write <= pwrite;
            ch_wdata <= pwdata;
            ch_strb  <= pstrb;
            if (idx_ok_s) begin
              state_r <= ACCESS;
              req_r   <= onehot_s;
            end else begin
              state_r <= DONE;
              pready  <= 1'b1;
              pslverr <= 1'b1;
              prdata  <= '0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_r <= IDLE;
            req_r   <= '0;
          end else if (ack_s) begin
            state_r <= DONE;
            req_r   <= '0;
            pready  <= 1'b1;
            pslverr <= err_s;
            prdata  <= (!ch_write && !err_s) ? rdata_s : '0;
          end else if (expired_s) begin
            state_r <= DONE;
            req_r   <= '0;
            pready  <= 1'b1;
            pslverr <= 1'b1;
            prdata  <= '0;
          end else begin
            state_r <= ACCESS;
          end
        end
        DONE: begin
          state_r <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          req_r   <= '0;
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
      endcase
    end
  end

endmodule
